// File: rtl/scs_job_sched.sv
// -----------------------------------------------------------------------------
// scs_job_sched
//
// Job scheduler and single-port payload RAM arbiter for the scs checksum
// engine. The host loads and reads back the payload while the scheduler is
// idle. A start pulse runs one checksum job: the engine is armed, given the
// RAM, watched for completion or timeout, and the RAM then goes back to the host.
//
// Build option:
//   SCS_JOB_SCHED_READBACK_EN - after the job, read the two checksum bytes at
//                               eng_len and eng_len+1 back into `result`.
//                               Without it `result` is tied to 0.
//
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   start, len           job request (sampled in IDLE) and payload length
//   busy, done, error    job status; done/error are one-cycle pulses
//   result               checksum read back (readback build only)
//   host_we/addr/wdata   host RAM port, honoured only while host_gnt=1
//   host_gnt             host owns the RAM port (scheduler idle)
//   eng_reset            engine reset (held while idle)
//   eng_mem_ready        engine go
//   eng_len              latched length for the engine
//   eng_work_complete    engine completion flag
//   eng_we/addr/wdata    engine RAM port
//   ram_we/addr/wdata    muxed RAM port
//   ram_rdata            RAM read data, valid one cycle after the address
//                        (fanned to the engine outside this block)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module scs_job_sched #(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_ADDR_BITS  = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [15:0]              len,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [15:0]              result,
  input  logic                     host_we,
  input  logic [RAM_ADDR_BITS-1:0] host_addr,
  input  logic [RAM_WIDTH-1:0]     host_wdata,
  output logic                     host_gnt,
  output logic                     eng_reset,
  output logic                     eng_mem_ready,
  output logic [15:0]              eng_len,
  input  logic                     eng_work_complete,
  input  logic                     eng_we,
  input  logic [RAM_ADDR_BITS-1:0] eng_addr,
  input  logic [RAM_WIDTH-1:0]     eng_wdata,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]     ram_wdata,
  input  logic [RAM_WIDTH-1:0]     ram_rdata
);

  // The two checksum bytes land at len and len+1, so len may not exceed
  // the RAM size minus two.
  localparam logic [16:0] MAX_LEN = 17'((1 << RAM_ADDR_BITS) - 2);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM0,   // engine held in reset
    S_ARM1,   // engine released, not yet told to go
    S_RUN,
    S_DRAIN,  // engine's last write has landed; engine back into reset
`ifdef SCS_JOB_SCHED_READBACK_EN
    S_RB0,
    S_RB1,
    S_RB2,
`endif
    S_FIN,
    S_ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      eng_len_q, eng_len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reject_q, reject_d;  // bad-length start, reported next cycle

`ifdef SCS_JOB_SCHED_READBACK_EN
  logic [15:0]      result_q, result_d;
`else
  logic             unused_rdata;
  assign unused_rdata = ^ram_rdata;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      eng_len_q <= '0;
      cnt_q     <= '0;
      reject_q  <= 1'b0;
`ifdef SCS_JOB_SCHED_READBACK_EN
      result_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      eng_len_q <= eng_len_d;
      cnt_q     <= cnt_d;
      reject_q  <= reject_d;
`ifdef SCS_JOB_SCHED_READBACK_EN
      result_q  <= result_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // skipped one would infer a latch.
    state_d       = state_q;
    eng_len_d     = eng_len_q;
    cnt_d         = '0;
    reject_d      = 1'b0;
`ifdef SCS_JOB_SCHED_READBACK_EN
    result_d      = result_q;
`endif
    busy          = 1'b0;
    done          = 1'b0;
    error         = reject_q;
    host_gnt      = 1'b0;
    eng_reset     = 1'b1;
    eng_mem_ready = 1'b0;
    ram_we        = eng_we;
    ram_addr      = eng_addr;
    ram_wdata     = eng_wdata;

    unique case (state_q)
      S_IDLE: begin
        host_gnt  = 1'b1;
        ram_we    = host_we;
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
        if (start) begin
          if ({1'b0, len} > MAX_LEN) begin
            reject_d = 1'b1;
          end else begin
            eng_len_d = len;
            state_d   = S_ARM0;
          end
        end
      end

      S_ARM0: begin
        busy    = 1'b1;
        state_d = S_ARM1;
      end

      S_ARM1: begin
        busy      = 1'b1;
        eng_reset = 1'b0;
        state_d   = S_RUN;
      end

      S_RUN: begin
        busy          = 1'b1;
        eng_reset     = 1'b0;
        eng_mem_ready = 1'b1;
        cnt_d         = cnt_q + CNT_W'(1);
        // Completion is checked first so it wins over a same-cycle timeout.
        if (eng_work_complete) begin
          state_d = S_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
        end
      end

      S_DRAIN: begin
        busy = 1'b1;
`ifdef SCS_JOB_SCHED_READBACK_EN
        state_d = S_RB0;
`else
        state_d = S_FIN;
`endif
      end

`ifdef SCS_JOB_SCHED_READBACK_EN
      // Synchronous RAM: each byte is captured one state after its address.
      S_RB0: begin
        busy     = 1'b1;
        ram_we   = 1'b0;
        ram_addr = eng_len_q[RAM_ADDR_BITS-1:0];
        state_d  = S_RB1;
      end

      S_RB1: begin
        busy            = 1'b1;
        ram_we          = 1'b0;
        ram_addr        = eng_len_q[RAM_ADDR_BITS-1:0] + RAM_ADDR_BITS'(1);
        result_d[15:8]  = ram_rdata[7:0];
        state_d         = S_RB2;
      end

      S_RB2: begin
        busy           = 1'b1;
        ram_we         = 1'b0;
        ram_addr       = eng_len_q[RAM_ADDR_BITS-1:0] + RAM_ADDR_BITS'(1);
        result_d[7:0]  = ram_rdata[7:0];
        state_d        = S_FIN;
      end
`endif

      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      S_ABORT: begin
        error   = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign eng_len = eng_len_q;
`ifdef SCS_JOB_SCHED_READBACK_EN
  assign result  = result_q;
`else
  assign result  = '0;
`endif

endmodule

// File: doc/scs_job_sched.md
Name: scs_job_sched

Overview:
- Job scheduler and RAM-port arbiter for the scs checksum engine.
- Owns the single-port payload RAM and shares it between a host port (payload load and readback) and the engine.
- Runs one checksum job per start pulse: arms the engine, hands it the RAM, waits for completion, returns RAM to the host.
- Enforces a length check and a watchdog timeout.

Parameters:
- RAM_WIDTH, 8, data width of RAM, host and engine ports.
- RAM_ADDR_BITS, 8, RAM address width.
- TIMEOUT_CYCLES, 4096, max cycles in RUN before abort (must be ≥ 4·2^RAM_ADDR_BITS + 8).

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  job request pulse, sampled only in IDLE
- len  in  16  payload length in bytes, latched on accepted start
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse, job completed OK
- error  out  1  one-cycle pulse, job rejected or timed out
- result  out  16  checksum read back (optional feature)
- host_we  in  1  host write strobe
- host_addr  in  RAM_ADDR_BITS  host address
- host_wdata  in  RAM_WIDTH  host write data
- host_gnt  out  1  host owns RAM port (combinational, =IDLE)
- eng_reset  out  1  engine reset
- eng_mem_ready  out  1  engine go
- eng_len  out  16  latched length to engine payload_len
- eng_work_complete  in  1  engine completion
- eng_we  in  1  engine write_enable
- eng_addr  in  RAM_ADDR_BITS  engine address
- eng_wdata  in  RAM_WIDTH  engine mem_input
- ram_we  out  1  RAM write enable
- ram_addr  out  RAM_ADDR_BITS  RAM address
- ram_wdata  out  RAM_WIDTH  RAM write data
- ram_rdata  in  RAM_WIDTH  RAM read data; synchronous, valid 1 cycle after address

Behaviour:
- Reset values:
  - state=IDLE, busy=0, done=0, error=0, result=0, eng_len=0.
  - eng_mem_ready=0, eng_reset=1 (engine held in reset while idle).
  - Timeout counter=0.
- RAM mux: host_gnt=1 selects host_* onto ram_*. Otherwise engine fields are selected, except in readback states, where the scheduler drives ram_addr and ram_we=0. Host writes outside IDLE are dropped.
- ram_rdata is fanned directly to the engine's mem_output.
- States and transitions:
  - IDLE: on start:
    - If len > 2^RAM_ADDR_BITS−2 (checksum bytes at len, len+1 would not fit): pulse error next cycle, stay IDLE.
    - Else: latch eng_len, busy=1 → ARM.
  - ARM, 2 cycles: eng_reset=1 for the first cycle, then 0 with eng_mem_ready=0, letting the engine pass through its RESET state to READY → RUN.
  - RUN: eng_mem_ready=1, counter increments each cycle.
    - On eng_work_complete=1 → DRAIN. The engine's second checksum write is issued in this same cycle.
    - On counter == TIMEOUT_CYCLES−1 → ABORT.
  - DRAIN, 1 cycle: eng_mem_ready=0, eng_reset=1, mux still on engine → RB0 if the feature is enabled, else FIN.
  - FIN: done=1 for 1 cycle, busy=0 → IDLE.
  - ABORT: eng_reset=1, error=1 for 1 cycle, busy=0, result unchanged → IDLE.
- Simultaneous events:
  - work_complete and timeout in the same cycle: work_complete wins.
  - start while busy: ignored.
  - start and host_we in the same IDLE cycle: the host write completes; the job is accepted.
- Latency: len=0 gives done 9 cycles after start (ARM 2, RUN ~5, DRAIN 1, FIN 1).
- Reset mid-job: immediate return to IDLE, engine held in reset, no done/error pulse.
- eng_len is stable for the whole job; a len change after accept has no effect.

Optional Feature:
- Macro: SCS_JOB_SCHED_READBACK_EN.
- With the macro:
  - DRAIN → RB0: ram_addr=eng_len. RB1: ram_addr=eng_len+1, capture result[15:8]. RB2: capture result[7:0] → FIN.
  - done is delayed 3 cycles versus without.
  - result is held until the next successful job.
- Without the macro: no RB states, result tied to 0.

Test Plan:
- Host writes 01 02 03 04 at addr 0–3; start, len=4 → done pulse, error=0; RAM[4]=0x00, RAM[5]=0x31; result=0x0031 with readback.
- Host writes 10 20 30 40 50; start, len=5 → RAM[5]=0x03, RAM[6]=0x60, result=0x0360.
- start, len=255 with RAM_ADDR_BITS=8 → error pulse next cycle, busy stays 0, RAM untouched, eng_reset stays 1.
- Engine model stalls eng_work_complete forever; start, len=4 → error at TIMEOUT_CYCLES after RUN entry; busy falls; next valid job then completes OK.
- During RUN: host_we=1 to addr 0x00 with data 0xAA, plus a second start → write dropped (RAM[0] unchanged), second start ignored, exactly one done.
- reset asserted in RUN → next cycle IDLE, busy=0, host_gnt=1, no done/error; a subsequent job with len=4 gives 0x0031.
